// File: rtl/convg_pkg.sv
// Shared types, constants and the round/saturate helper for the streaming 3x3 convolution.
package convg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam logic BORDER_ZERO = 1'b0;
  localparam logic BORDER_REPL = 1'b1;

  // Unity-gain Gaussian-class kernel: 4*3 + 4*14 + 60 = 128 = 1 << 7
  localparam int unsigned W_CORNER_DEF = 3;
  localparam int unsigned W_EDGE_DEF   = 14;
  localparam int unsigned W_CENTER_DEF = 60;
  localparam int unsigned SHIFT_DEF    = 7;

  function automatic logic [7:0] sat_round(input logic [31:0] acc, input logic [3:0] sh);
    logic [31:0] r;
    r = (acc + ((sh != 4'd0) ? (32'd1 << (sh - 4'd1)) : 32'd0)) >> sh;
    return (r > 32'd255) ? 8'hFF : r[7:0];
  endfunction

endpackage

// File: rtl/convg_pu.sv
// Single-pixel 3x3 MAC: products in stage 1, sum/round/saturate in stage 2.
module convg_pu
  import convg_pkg::*;
#(
  parameter int unsigned COEF_W = 8,
  parameter int unsigned ACC_W  = 20
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_mul_i,
  input  logic              en_sum_i,
  input  logic [7:0]        p_i,
  input  logic [9:0]        sum_e_i,
  input  logic [9:0]        sum_c_i,
  input  logic [COEF_W-1:0] w_center_i,
  input  logic [COEF_W-1:0] w_edge_i,
  input  logic [COEF_W-1:0] w_corner_i,
  input  logic [3:0]        shift_i,
  output logic [7:0]        pix_o
);

  logic [ACC_W-1:0] pc_q, pe_q, pk_q;
  logic [ACC_W-1:0] acc;
  logic [7:0]       pix_q;

  assign acc   = pc_q + pe_q + pk_q;
  assign pix_o = pix_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_q  <= '0;
      pe_q  <= '0;
      pk_q  <= '0;
      pix_q <= '0;
    end else begin
      if (en_mul_i) begin
        pc_q <= ACC_W'(w_center_i) * ACC_W'(p_i);
        pe_q <= ACC_W'(w_edge_i) * ACC_W'(sum_e_i);
        pk_q <= ACC_W'(w_corner_i) * ACC_W'(sum_c_i);
      end
      if (en_sum_i) pix_q <= sat_round(32'(acc), shift_i);
    end
  end

endmodule

// File: rtl/convg_stream3x3.sv
// Streaming 3x3 symmetric convolution, NPU pixels per beat, with line buffers,
// border handling, last-row flush and valid/ready backpressure.
module convg_stream3x3
  import convg_pkg::*;
#(
  parameter int unsigned IM_LEN            = 520,
  parameter int unsigned IM_ROWS           = 520,
  parameter int unsigned NO_PARALLEL_UNITS = 4,
  parameter int unsigned COEF_W            = 8,
  parameter int unsigned ACC_W             = 20
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic                           clrbuffer,
  input  logic [COEF_W-1:0]              w_corner,
  input  logic [COEF_W-1:0]              w_edge,
  input  logic [COEF_W-1:0]              w_center,
  input  logic [3:0]                     shift,
  input  logic                           border_mode,
  input  logic [NO_PARALLEL_UNITS*8-1:0] data_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [NO_PARALLEL_UNITS*8-1:0] data_out,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           frame_done
);

  localparam int unsigned NPU  = NO_PARALLEL_UNITS;
  localparam int unsigned DW   = NPU * 8;
  localparam int unsigned COLS = IM_LEN / NPU;
  localparam int unsigned CW   = $clog2(COLS + 2);
  localparam int unsigned RW   = $clog2(IM_ROWS + 1);
  localparam int unsigned AW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [CW-1:0] COL_END  = CW'(COLS);
  localparam logic [CW-1:0] COL_DONE = CW'(COLS + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IM_ROWS - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              alive_q, s1_valid_q, out_valid_q, frame_done_q;
  logic [COEF_W-1:0] wc_q, we_q, wk_q;
  logic [3:0]        sh_q;
  logic              mode_q;

  logic [DW-1:0]     lb0_q [COLS];
  logic [DW-1:0]     lb1_q [COLS];
  logic [DW-1:0]     prev_t_q, prev_m_q, prev_b_q;
  logic [7:0]        lft_t_q, lft_m_q, lft_b_q;
  logic              prev_first_q;

  logic              hold, adv, accept, fstep, step, emit, last_acc, rb, top_sub, flushing;
  logic [AW-1:0]     idx;
  logic [DW-1:0]     cur_t, cur_m, cur_b;
  logic [7:0]        wt [NPU+2];
  logic [7:0]        wm [NPU+2];
  logic [7:0]        wb [NPU+2];

  assign hold     = out_valid_q & ~out_ready;
  assign adv      = ~hold;
  assign flushing = (state_q == FLUSH);
  assign in_ready = alive_q & ~flushing & adv;
  assign accept   = in_valid & in_ready & ~clrbuffer;
  assign fstep    = flushing & adv & ~clrbuffer & (col_q <= COL_END);
  assign step     = accept | fstep;
  // Output lags input by one beat; beat 0 of a row emits the previous row's last beat.
  assign emit     = fstep | (accept & (((row_q != '0) & (col_q != '0)) |
                                       ((row_q > RW'(1)) & (col_q == '0))));
  assign last_acc = flushing & (col_q == COL_DONE) & ~s1_valid_q & out_valid_q & out_ready;
  assign rb       = (col_q == '0) | (col_q == COL_END);
  assign top_sub  = ~flushing & (row_q == RW'(1));
  assign idx      = (col_q < COL_END) ? AW'(col_q) : '0;

  assign cur_m = lb1_q[idx];
  assign cur_t = top_sub  ? (mode_q ? cur_m : '0) : lb0_q[idx];
  assign cur_b = flushing ? (mode_q ? cur_m : '0) : data_in;

  always_comb begin
    for (int unsigned k = 0; k < NPU; k++) begin
      wt[k+1] = prev_t_q[8*k +: 8];
      wm[k+1] = prev_m_q[8*k +: 8];
      wb[k+1] = prev_b_q[8*k +: 8];
    end
    wt[0]     = prev_first_q ? (mode_q ? prev_t_q[7:0] : '0) : lft_t_q;
    wm[0]     = prev_first_q ? (mode_q ? prev_m_q[7:0] : '0) : lft_m_q;
    wb[0]     = prev_first_q ? (mode_q ? prev_b_q[7:0] : '0) : lft_b_q;
    wt[NPU+1] = rb ? (mode_q ? prev_t_q[DW-1 -: 8] : '0) : cur_t[7:0];
    wm[NPU+1] = rb ? (mode_q ? prev_m_q[DW-1 -: 8] : '0) : cur_m[7:0];
    wb[NPU+1] = rb ? (mode_q ? prev_b_q[DW-1 -: 8] : '0) : cur_b[7:0];
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (clrbuffer) begin
      state_d = IDLE;
      col_d   = '0;
      row_d   = '0;
    end else if (flushing) begin
      if (fstep) col_d = col_q + CW'(1);
      if (last_acc) begin
        state_d = IDLE;
        col_d   = '0;
        row_d   = '0;
      end
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) state_d = FLUSH;
        else begin
          row_d   = row_q + RW'(1);
          state_d = RUN;
        end
      end else begin
        col_d = col_q + CW'(1);
        if (state_q == IDLE) state_d = FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      alive_q      <= 1'b0;
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      wc_q         <= COEF_W'(W_CENTER_DEF);
      we_q         <= COEF_W'(W_EDGE_DEF);
      wk_q         <= COEF_W'(W_CORNER_DEF);
      sh_q         <= 4'(SHIFT_DEF);
      mode_q       <= BORDER_REPL;
    end else begin
      alive_q <= 1'b1;
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      if (clrbuffer) begin
        s1_valid_q   <= 1'b0;
        out_valid_q  <= 1'b0;
        frame_done_q <= 1'b0;
      end else begin
        if (adv) begin
          s1_valid_q  <= emit;
          out_valid_q <= s1_valid_q;
        end
        frame_done_q <= last_acc;
      end
      if (accept && state_q == IDLE) begin
        wc_q   <= w_center;
        we_q   <= w_edge;
        wk_q   <= w_corner;
        sh_q   <= shift;
        mode_q <= border_mode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_q[idx] <= lb1_q[idx];
      lb1_q[idx] <= data_in;
    end
    if (step) begin
      prev_t_q     <= cur_t;
      prev_m_q     <= cur_m;
      prev_b_q     <= cur_b;
      lft_t_q      <= prev_t_q[DW-1 -: 8];
      lft_m_q      <= prev_m_q[DW-1 -: 8];
      lft_b_q      <= prev_b_q[DW-1 -: 8];
      prev_first_q <= (col_q == '0);
    end
  end

  for (genvar k = 0; k < NPU; k++) begin : g_pu
    logic [9:0] se, sc;
    assign se = 10'(wt[k+1]) + 10'(wb[k+1]) + 10'(wm[k]) + 10'(wm[k+2]);
    assign sc = 10'(wt[k]) + 10'(wt[k+2]) + 10'(wb[k]) + 10'(wb[k+2]);
    convg_pu #(.COEF_W(COEF_W), .ACC_W(ACC_W)) u_pu (
      .clk_i     (clk),
      .rst_n_i   (res),
      .en_mul_i  (emit),
      .en_sum_i  (adv & s1_valid_q & ~clrbuffer),
      .p_i       (wm[k+1]),
      .sum_e_i   (se),
      .sum_c_i   (sc),
      .w_center_i(wc_q),
      .w_edge_i  (we_q),
      .w_corner_i(wk_q),
      .shift_i   (sh_q),
      .pix_o     (data_out[8*k +: 8])
    );
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_convg_stream3x3.sv
// Directed scoreboard bench for convg_stream3x3 on an 8x4 image, 4 pixels per beat.
module tb_convg_stream3x3;
  import convg_pkg::*;

  localparam int L = 8;
  localparam int R = 4;
  localparam int N = 4;
  localparam int C = L / N;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          clrbuffer = 1'b0;
  logic [7:0]    w_corner, w_edge, w_center;
  logic [3:0]    shift;
  logic          border_mode;
  logic [N*8-1:0] data_in;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N*8-1:0] data_out;
  logic          out_valid;
  logic          out_ready;
  logic          frame_done;

  int            n_chk = 0;
  int            n_fail = 0;
  int            beat_cnt = 0;
  int            fd_cnt = 0;
  bit            toggle_en = 1'b0;
  logic [31:0]   exp_q [$];

  always #5 clk = ~clk;

  convg_stream3x3 #(
    .IM_LEN(L), .IM_ROWS(R), .NO_PARALLEL_UNITS(N), .COEF_W(8), .ACC_W(20)
  ) dut (
    .clk(clk), .res(res), .clrbuffer(clrbuffer),
    .w_corner(w_corner), .w_edge(w_edge), .w_center(w_center),
    .shift(shift), .border_mode(border_mode),
    .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Test ids: 0 flat100 replicate, 1 flat100 zero-pad, 2 impulse zero-pad,
  // 3 flat200 heavy weights (saturates), 4 flat100 replicate with backpressure.
  function automatic logic [7:0] pix(input int t, input int r, input int c);
    if (t == 2) return (r == 1 && c == 1) ? 8'd255 : 8'd0;
    if (t == 3) return 8'd200;
    return 8'd100;
  endfunction

  function automatic logic [7:0] expv(input int t, input int r, input int c);
    int dr, dc;
    bit er, ec;
    dr = (r > 1) ? r - 1 : 1 - r;
    dc = (c > 1) ? c - 1 : 1 - c;
    er = (r == 0) || (r == R - 1);
    ec = (c == 0) || (c == L - 1);
    case (t)
      1: return (er && ec) ? 8'd71 : ((er || ec) ? 8'd84 : 8'd100);
      2: begin
        if (dr == 0 && dc == 0) return 8'd120;
        if (dr + dc == 1) return 8'd28;
        if (dr == 1 && dc == 1) return 8'd6;
        return 8'd0;
      end
      3: return 8'd255;
      default: return 8'd100;
    endcase
  endfunction

  initial begin : monitor
    logic        held;
    logic [31:0] hd;
    held = 1'b0;
    hd = '0;
    forever begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (held && out_valid) check("data_out stable under hold", data_out, hd);
      if (out_valid && !out_ready) check("in_ready low under hold", {31'b0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected beat: got %0h, expected none", data_out);
        end else begin
          check("output beat", data_out, exp_q.pop_front());
        end
      end
      held = out_valid && !out_ready;
      hd = data_out;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle_en ? ~out_ready : 1'b1;
    end
  end

  task automatic run_frame(input int t, input int abort_kind);
    int          fd0, bt0;
    bit          got;
    logic [31:0] w;
    w_center    = (t == 3) ? 8'd60 : 8'(W_CENTER_DEF);
    w_edge      = (t == 3) ? 8'd60 : 8'(W_EDGE_DEF);
    w_corner    = (t == 3) ? 8'd60 : 8'(W_CORNER_DEF);
    shift       = 4'(SHIFT_DEF);
    border_mode = (t == 1 || t == 2) ? BORDER_ZERO : BORDER_REPL;
    toggle_en   = (t == 4);
    for (int r = 0; r < R; r++)
      for (int b = 0; b < C; b++) begin
        for (int k = 0; k < N; k++) w[8*k +: 8] = expv(t, r, b * N + k);
        exp_q.push_back(w);
      end
    fd0 = fd_cnt;
    bt0 = beat_cnt;
    for (int r = 0; r < R; r++) begin
      for (int b = 0; b < C; b++) begin
        for (int k = 0; k < N; k++) data_in[8*k +: 8] = pix(t, r, b * N + k);
        if (abort_kind != 0 && r == 2 && b == 1) begin
          if (abort_kind == 1) begin
            clrbuffer = 1'b1;
            in_valid  = 1'b1;
            @(posedge clk);
            #1;
            clrbuffer = 1'b0;
            in_valid  = 1'b0;
          end else begin
            in_valid = 1'b0;
            res = 1'b0;
            #1;
            check("out_valid low in reset", {31'b0, out_valid}, 32'd0);
            check("in_ready low in reset", {31'b0, in_ready}, 32'd0);
            #1;
            res = 1'b1;
          end
          exp_q.delete();
          fd0 = fd_cnt;
          bt0 = beat_cnt;
          repeat (20) @(posedge clk);
          #1;
          check("no frame_done after abort", fd_cnt - fd0, 0);
          check("no output after abort", beat_cnt - bt0, 0);
          toggle_en = 1'b0;
          return;
        end
        in_valid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
          @(negedge clk);
          got = in_ready;
          @(posedge clk);
          #1;
        end
        if (!got) check("input accept timeout", 0, 1);
        if (r == 0 && b == 0) begin
          // Configuration must stay latched from the first beat.
          w_center    = 8'd0;
          w_edge      = 8'hFF;
          w_corner    = 8'd0;
          shift       = 4'd15;
          border_mode = ~border_mode;
        end
      end
    end
    in_valid = 1'b0;
    for (int n = 0; n < 300 && fd_cnt == fd0; n++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    check("frame_done pulses", fd_cnt - fd0, 1);
    check("output beats", beat_cnt - bt0, C * R);
    check("scoreboard drained", exp_q.size(), 0);
    toggle_en = 1'b0;
  endtask

  initial begin
    w_center    = 8'(W_CENTER_DEF);
    w_edge      = 8'(W_EDGE_DEF);
    w_corner    = 8'(W_CORNER_DEF);
    shift       = 4'(SHIFT_DEF);
    border_mode = BORDER_REPL;
    data_in     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset data_out", data_out, 32'd0);
    check("reset frame_done", {31'b0, frame_done}, 32'd0);
    check("reset in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    res = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_frame(0, 0);
    run_frame(1, 0);
    run_frame(2, 0);
    run_frame(3, 0);
    run_frame(4, 0);
    run_frame(0, 1);
    run_frame(1, 0);
    run_frame(3, 2);
    run_frame(2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
